// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port identifiers and the default loader starvation limit.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam int unsigned MAX_WAIT_DEF = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve_cnt
// Counts how many arbitrations the loader has lost to the core and raises
// override_o once that count reaches MAX_WAIT, so the loader is not starved.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   inc_i      in   loader requested but core won this arbitration
//   clr_i      in   loader won this arbitration
//   l_req_i    in   loader request
//   override_o out  loader must win the next arbitration it takes part in
// ---------------------------------------------------------------------------
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    input  logic l_req_i,
    output logic override_o
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign override_o = l_req_i && (cnt_q >= MAX_WAIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester (core, loader) arbiter in front of a single-ported data
// memory. One access outstanding at a time: IDLE arbitrates and latches the
// winner's request, ISSUE drives the memory strobes and grants, RESP returns
// read data one cycle after the read strobe.
//
// Ports
//   clk, reset                      clock; asynchronous active-low reset
//   c_req/c_wr/c_addr/c_wdata       core request (wr=1 write, 0 read)
//   c_gnt/c_rvalid                  core grant / read-valid pulses
//   l_req/l_wr/l_addr/l_wdata       loader request
//   l_gnt/l_rvalid                  loader grant / read-valid pulses
//   rdata                           read data, zero unless an rvalid is high
//   mem_rd/mem_wr                   memory read / write strobes
//   mem_addr/mem_wdata              memory address / write data
//   mem_rdata                       memory read data, cycle after mem_rd
//   busy                            high whenever not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              l_req,
    input  logic              l_wr,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e state_q, state_d;

    logic              id_q, id_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic c_gnt_q, c_gnt_d;
    logic l_gnt_q, l_gnt_d;
    logic c_rv_q, c_rv_d;
    logic l_rv_q, l_rv_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;

    logic              any_req;
    logic              override;
    logic              loader_win;
    logic              arb;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req    = c_req || l_req;
    assign loader_win = l_req && (!c_req || override);
    assign arb        = (state_q == ST_IDLE) && any_req;
    assign sel_wr     = loader_win ? l_wr    : c_wr;
    assign sel_addr   = loader_win ? l_addr  : c_addr;
    assign sel_wdata  = loader_win ? l_wdata : c_wdata;

    // Counter only moves on real arbitrations; it holds through ISSUE/RESP.
    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (arb && l_req && !loader_win),
        .clr_i      (arb && loader_win),
        .l_req_i    (l_req),
        .override_o (override)
    );

    // Pulses are computed one state ahead so they come straight from flops
    // during the state they belong to.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        c_gnt_d  = 1'b0;
        l_gnt_d  = 1'b0;
        c_rv_d   = 1'b0;
        l_rv_d   = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_ISSUE;
                    id_d     = loader_win ? PORT_LOADER : PORT_CORE;
                    wr_d     = sel_wr;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    c_gnt_d  = !loader_win;
                    l_gnt_d  = loader_win;
                    mem_wr_d = sel_wr;
                    mem_rd_d = !sel_wr;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                    c_rv_d  = (id_q == PORT_CORE);
                    l_rv_d  = (id_q == PORT_LOADER);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            id_q     <= PORT_CORE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            c_gnt_q  <= 1'b0;
            l_gnt_q  <= 1'b0;
            c_rv_q   <= 1'b0;
            l_rv_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            c_gnt_q  <= c_gnt_d;
            l_gnt_q  <= l_gnt_d;
            c_rv_q   <= c_rv_d;
            l_rv_q   <= l_rv_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign c_gnt     = c_gnt_q;
    assign l_gnt     = l_gnt_q;
    assign c_rvalid  = c_rv_q;
    assign l_rvalid  = l_rv_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign rdata     = (c_rv_q || l_rv_q) ? mem_rdata : '0;

endmodule
